bcd_display_scanner: RTL and testbench
======================================

// Module: bcd_display_scanner
// PURPOSE
//   Upstream driver for the seven-segment hex decoder on the Basys3 4-digit display.
//   Converts a binary value (0..9999) to BCD with an iterative double-dabble FSM.
//   Time-multiplexes the four digits: drives the active-low anodes and supplies one
//   4-bit digit code per scan slot. Code 4'hF marks a blank digit.
// PARAMETERS
//   REFRESH_DIV  100000  clk cycles per digit slot (>=1); 100000 gives 1 kHz per digit at 100 MHz
//   BLANK_LZ     1       1: leading-zero digits shown as 4'hF (digit 0 never blanked); 0: show zeros
// PORTS
//   clk        in   1   system clock, all state on rising edge
//   rst        in   1   asynchronous, active-high reset
//   bin_in     in   14  binary value to display; sampled when load is accepted
//   load       in   1   request conversion of bin_in; accepted only while busy=0
//   busy       out  1   conversion in progress
//   ovf        out  1   last committed value was >9999
//   digit_val  out  4   BCD digit for the active anode (to the decoder), 4'hF = blank
//   an         out  4   anode enables, active-low, one-hot-zero; an[0] = rightmost digit
// BEHAVIOUR
//   Reset (async, any time, including mid-conversion):
//     FSM=IDLE; busy=0; ovf=0; disp (4 nibbles)=4'hF each; prescaler=0; idx=0
//     an=4'b1110; digit_val=4'hF. A conversion in progress is discarded.
//   Conversion FSM, states IDLE / CONV:
//     IDLE & load=1 (edge E0): capture bin_in in a 14-bit shift reg; clear BCD accumulator
//       and iteration count; latch ovf_pend=(bin_in>9999); go to CONV; busy=1.
//     CONV, edges E1..E14, one iteration each:
//       - add 3 to every accumulator nibble >=5;
//       - shift {acc,shreg} left by 1.
//     At E14, commit and go to IDLE (busy=1 for exactly 14 cycles):
//       - ovf_pend=1: disp=all 4'hF, ovf=1;
//       - else: disp=BCD, with blanking per BLANK_LZ, ovf=0.
//     load while busy: ignored (no queueing). load held high in IDLE restarts the
//       conversion every 15 cycles.
//     Leading-zero blank (BLANK_LZ=1): blank from digit 3 down while the nibble is 0,
//       stopping at digit 1; digit 0 is always shown.
//     Accumulator width: 16 bits (4 nibbles); no carry out for bin_in<=9999.
//   Scanner (runs continuously, independent of FSM):
//     prescaler counts 0..REFRESH_DIV-1 and wraps. On wrap, idx (2 bit) increments mod 4;
//       idx 3 -> 0 wraps.
//     Every edge: an <= ~(4'b0001<<idx); digit_val <= disp[idx]. Both are registered from
//       the same idx, so they always change on the same edge, one cycle after idx/disp changes.
//     A commit mid-slot updates digit_val on the next edge; the slot timing is unaffected.
//     REFRESH_DIV=1: idx advances every cycle.
// TESTING (bench uses REFRESH_DIV=4, BLANK_LZ=1 unless stated)
//   1. Assert rst mid-run -> an=1110, digit_val=F, busy=0, ovf=0 immediately (async);
//      after release, an walks 1110,1101,1011,0111 with 4 cycles per slot, digit_val=F.
//   2. load bin_in=1234 -> busy high exactly 14 cycles; then digit_val=4,3,2,1 on
//      an=1110,1101,1011,0111; ovf=0.
//   3. Leading zeros:
//      - load 7 -> digits (0..3)=7,F,F,F;
//      - load 0 -> 0,F,F,F;
//      - load 1005 -> 5,0,0,1;
//      - rerun with BLANK_LZ=0 and load 7 -> 7,0,0,0.
//   4. Overflow:
//      - load 10000 -> ovf=1, all digits F;
//      - load 16383 -> ovf=1;
//      - load 9999 -> ovf=0, digits 9,9,9,9.
//   5. load 42, then load 77 on cycle 5 of busy -> 77 ignored, display 2,4,F,F;
//      assert rst at cycle 7 of a conversion of 5555 -> busy=0, display blank, no later commit.
//   6. REFRESH_DIV=1 -> an changes every cycle and wraps 0111 -> 1110;
//      digit_val stays coherent with an on every cycle.

Source files
------------

// File: rtl/bcd_display_if.sv
// Bus between a value source and the 4-digit display scanner:
// the load request plus the status and the scan outputs.
interface bcd_display_if;
    logic [13:0] bin_in;
    logic        load;
    logic        busy;
    logic        ovf;
    logic [3:0]  digit_val;
    logic [3:0]  an;

    modport master (output bin_in, load, input busy, ovf, digit_val, an);
    modport slave  (input bin_in, load, output busy, ovf, digit_val, an);
endinterface

// File: rtl/bcd_display_scanner.sv
// Binary-to-BCD conversion by iterative double-dabble, plus a continuous
// time-multiplexed scan of the four digits onto active-low anodes.
module bcd_display_scanner #(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    bcd_display_if.slave  bus
);
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);

    typedef enum logic {IDLE, CONV} state_t;

    state_t          state;
    logic [13:0]     shreg;
    logic [15:0]     acc;
    logic [3:0]      iter;
    logic            ovf_pend;
    logic            busy;
    logic            ovf;
    logic [3:0][3:0] disp;

    logic [PW-1:0]   prescaler;
    logic [1:0]      idx;
    logic [3:0]      an;
    logic [3:0]      digit_val;

    logic [15:0]     acc_adj;
    logic [15:0]     acc_next;
    logic [13:0]     shreg_next;

    // One double-dabble step: nibble correction, then shift {acc,shreg} left.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < 4; i++) begin
            if (acc[4*i +: 4] >= 4'd5)
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
        {acc_next, shreg_next} = {acc_adj, shreg} << 1;
    end

    function automatic logic [15:0] blank_lz(input logic [15:0] bcd);
        logic [15:0] res;
        logic        lead;
        res  = bcd;
        lead = BLANK_LZ;
        for (int i = 3; i >= 1; i--) begin
            if (lead && bcd[4*i +: 4] == 4'd0)
                res[4*i +: 4] = 4'hF;
            else
                lead = 1'b0;
        end
        return res;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: disp is a four-nibble register, not a RAM, so resetting it to blank costs nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            acc      <= '0;
            iter     <= '0;
            ovf_pend <= 1'b0;
            busy     <= 1'b0;
            ovf      <= 1'b0;
            disp     <= {4{4'hF}};
        end else begin
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        shreg    <= bus.bin_in;
                        acc      <= '0;
                        iter     <= '0;
                        ovf_pend <= (bus.bin_in > 14'd9999);
                        busy     <= 1'b1;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    acc   <= acc_next;
                    shreg <= shreg_next;
                    iter  <= iter + 4'd1;
                    if (iter == 4'd13) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                        if (ovf_pend) begin
                            disp <= {4{4'hF}};
                            ovf  <= 1'b1;
                        end else begin
                            disp <= blank_lz(acc_next);
                            ovf  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Anode and digit are registered from the same idx so they stay coherent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            idx       <= '0;
            an        <= 4'b1110;
            digit_val <= 4'hF;
        end else begin
            if (prescaler == PRE_MAX) begin
                prescaler <= '0;
                idx       <= idx + 2'd1;
            end else begin
                prescaler <= prescaler + 1'b1;
            end
            an        <= ~(4'b0001 << idx);
            digit_val <= disp[idx];
        end
    end

    assign bus.busy      = busy;
    assign bus.ovf       = ovf;
    assign bus.an        = an;
    assign bus.digit_val = digit_val;
endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner: three instances cover REFRESH_DIV=4,
// REFRESH_DIV=1 and BLANK_LZ=0; expected displays come from a decimal model.
module tb_bcd_display_scanner;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bcd_display_if if0 ();
    bcd_display_if if1 ();
    bcd_display_if if2 ();

    bcd_display_scanner #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    bcd_display_scanner #(.REFRESH_DIV(1), .BLANK_LZ(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    bcd_display_scanner #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

    logic [2:0]       load_a = '0;
    logic [2:0][13:0] bin_a  = '0;
    logic [2:0]       busy_a, ovf_a;
    logic [2:0][3:0]  an_a, dv_a;

    assign if0.load = load_a[0];  assign if0.bin_in = bin_a[0];
    assign if1.load = load_a[1];  assign if1.bin_in = bin_a[1];
    assign if2.load = load_a[2];  assign if2.bin_in = bin_a[2];
    assign busy_a = {if2.busy, if1.busy, if0.busy};
    assign ovf_a  = {if2.ovf,  if1.ovf,  if0.ovf};
    assign an_a   = {if2.an,   if1.an,   if0.an};
    assign dv_a   = {if2.digit_val, if1.digit_val, if0.digit_val};

    typedef struct packed {
        logic            ovf;
        logic [3:0][3:0] d;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int v, input bit blz);
        exp_t e;
        bit   lead;
        e.ovf = (v > 9999);
        for (int i = 0; i < 4; i++) begin
            int p = 1;
            for (int j = 0; j < i; j++) p = p * 10;
            e.d[i] = e.ovf ? 4'hF : 4'((v / p) % 10);
        end
        lead = blz;
        for (int i = 3; i >= 1; i--) begin
            if (lead && e.d[i] == 4'd0) e.d[i] = 4'hF;
            else lead = 1'b0;
        end
        return e;
    endfunction

    // Load v into instance 'which'; optionally pulse a second load (inj_v)
    // on busy cycle inj_cyc. Then check busy length, ovf and a full scan.
    task automatic run_conv(input int which, input int v, input int inj_cyc, input int inj_v);
        exp_t       e;
        int         cnt, guard, idx;
        bit         ok;
        logic [3:0] prev_an;
        sb.push_back(model(v, which != 2));
        @(negedge clk);
        bin_a[which]  = 14'(v);
        load_a[which] = 1'b1;
        cnt = 0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
            if (busy_a[which]) cnt++;
            if (busy_a[which] && cnt == inj_cyc) begin
                load_a[which] = 1'b1;
                bin_a[which]  = 14'(inj_v);
            end else begin
                load_a[which] = 1'b0;
            end
        end while (busy_a[which] && guard < 40);
        check($sformatf("busy_cycles[%0d]=%0d", which, v), 16'(cnt), 16'd14);
        e = sb.pop_front();
        check($sformatf("ovf[%0d]=%0d", which, v), {15'd0, ovf_a[which]}, {15'd0, e.ovf});
        prev_an = an_a[which];
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            ok = 1'b1;
            case (an_a[which])
                4'b1110: idx = 0;
                4'b1101: idx = 1;
                4'b1011: idx = 2;
                4'b0111: idx = 3;
                default: begin idx = 0; ok = 1'b0; end
            endcase
            check($sformatf("an_onehot[%0d]", which), {15'd0, ok}, 16'd1);
            if (ok)
                check($sformatf("digit[%0d] v=%0d slot=%0d", which, v, idx),
                      {12'd0, dv_a[which]}, {12'd0, e.d[idx]});
            if (which == 1)
                check("an_step_every_cycle", {15'd0, an_a[1] != prev_an}, 16'd1);
            prev_an = an_a[which];
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int w = 0; w < 3; w++) begin
            check($sformatf("%s busy[%0d]", tag, w), {15'd0, busy_a[w]}, 16'd0);
            check($sformatf("%s ovf[%0d]", tag, w),  {15'd0, ovf_a[w]},  16'd0);
            check($sformatf("%s an[%0d]", tag, w),   {12'd0, an_a[w]},   16'h000E);
            check($sformatf("%s dv[%0d]", tag, w),   {12'd0, dv_a[w]},   16'h000F);
        end
    endtask

    initial begin
        logic [3:0] one;
        one = 4'b0001;

        #2 rst = 1'b1;
        #1 check_reset_state("por");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_conv(0, 1234, 0, 0);
        run_conv(0, 10000, 0, 0);

        // Asynchronous reset mid-run, then the anode walk from a clean prescaler.
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_state("midrun");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check($sformatf("walk_an0 k=%0d", k), {12'd0, an_a[0]}, {12'd0, ~(one << ((k - 1) / 4))});
            check($sformatf("walk_an1 k=%0d", k), {12'd0, an_a[1]}, {12'd0, ~(one << ((k - 1) % 4))});
            check($sformatf("walk_dv0 k=%0d", k), {12'd0, dv_a[0]}, 16'h000F);
        end

        run_conv(0, 7, 0, 0);
        run_conv(0, 0, 0, 0);
        run_conv(0, 1005, 0, 0);
        run_conv(2, 7, 0, 0);
        run_conv(0, 16383, 0, 0);
        run_conv(0, 9999, 0, 0);
        run_conv(0, 42, 5, 77);
        run_conv(1, 1234, 0, 0);

        // Reset on busy cycle 7 of a 5555 conversion must discard it.
        @(negedge clk);
        bin_a[0]  = 14'd5555;
        load_a[0] = 1'b1;
        @(negedge clk);
        load_a[0] = 1'b0;
        repeat (6) @(negedge clk);
        check("busy_before_abort", {15'd0, busy_a[0]}, 16'd1);
        #2 rst = 1'b1;
        #1 check_reset_state("abort");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            check($sformatf("abort_busy k=%0d", k), {15'd0, busy_a[0]}, 16'd0);
            check($sformatf("abort_dv k=%0d", k), {12'd0, dv_a[0]}, 16'h000F);
        end

        check("scoreboard_empty", 16'(sb.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
